turn_controller: RTL



---
 rtl/turn_pkg.sv | 18 +
 rtl/sec_prescaler.sv | 19 +
 rtl/turn_controller.sv | 99 +++++++++
 3 files changed

// File: rtl/turn_pkg.sv
// turn_pkg: shared state encoding, player/winner codes and BCD helpers for the turn controller
package turn_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, SWITCH = 2'd2, OVER = 2'd3} state_t;
  localparam logic [3:0] P1 = 4'd1;
  localparam logic [3:0] P2 = 4'd2;
  localparam logic [3:0] WINNER_TIE = 4'hF;
  localparam logic [3:0] WINNER_NONE = 4'd0;
  localparam int DEFAULT_TURN_SECONDS = 15;
  function automatic logic [3:0] bcd_tens(input int s);
    return 4'(s / 10);
  endfunction
  function automatic logic [3:0] bcd_ones(input int s);
    return 4'(s % 10);
  endfunction
  function automatic logic [3:0] winner_of(input logic [3:0] a, input logic [3:0] b);
    return a > b ? P1 : b > a ? P2 : WINNER_TIE;
  endfunction
endpackage

// File: rtl/sec_prescaler.sv
// sec_prescaler: divides the system clock into a one-cycle pulse per second
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic sec_tick
);
  localparam int W = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);
  logic [W-1:0] count;
  assign sec_tick = enable && count == LAST;
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) count <= '0;
    else if (enable) count <= sec_tick ? '0 : count + W'(1);
  end
endmodule

// File: rtl/turn_controller.sv
// turn_controller: two-player card-match sequencer owning turn, countdown, scores and winner
module turn_controller
  import turn_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int TURN_SECONDS = DEFAULT_TURN_SECONDS,
  parameter int TOTAL_PAIRS = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       match_valid,
  input  logic       match_hit,
  output logic [3:0] player_digit,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [3:0] timer_tens,
  output logic [3:0] timer_ones,
  output logic [3:0] winner_digit,
  output logic       game_over
);
  localparam int PW = $clog2(TOTAL_PAIRS + 1);
  localparam logic [3:0] R_TENS = bcd_tens(TURN_SECONDS);
  localparam logic [3:0] R_ONES = bcd_ones(TURN_SECONDS);
  state_t state;
  logic [PW-1:0] pairs;
  logic sec_tick, hit, miss, last_pair;
  logic [3:0] cur_score, new_score, new_p1, new_p2;
  sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_prescaler (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .enable(state == PLAY),
    .clear(state != PLAY || match_valid),
    .sec_tick(sec_tick)
  );
  always_comb begin
    hit = state == PLAY && match_valid && match_hit;
    miss = state == PLAY && match_valid && !match_hit;
    cur_score = player_digit == P1 ? score_p1 : score_p2;
    new_score = cur_score == 4'd9 ? 4'd9 : cur_score + 4'd1;
    new_p1 = player_digit == P1 ? new_score : score_p1;
    new_p2 = player_digit == P2 ? new_score : score_p2;
    last_pair = pairs == PW'(TOTAL_PAIRS - 1);
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      player_digit <= P1;
      score_p1 <= '0;
      score_p2 <= '0;
      timer_tens <= R_TENS;
      timer_ones <= R_ONES;
      winner_digit <= WINNER_NONE;
      game_over <= 1'b0;
      pairs <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= PLAY;
        PLAY:
          if (hit) begin
            score_p1 <= new_p1;
            score_p2 <= new_p2;
            pairs <= pairs + PW'(1);
            timer_tens <= R_TENS;
            timer_ones <= R_ONES;
            if (last_pair) begin
              state <= OVER;
              game_over <= 1'b1;
              winner_digit <= winner_of(new_p1, new_p2);
            end
          end else if (miss) state <= SWITCH;
          else if (sec_tick) begin
            // BCD decrement; reaching 00 ends the turn on a timeout
            timer_ones <= timer_ones == 4'd0 ? 4'd9 : timer_ones - 4'd1;
            timer_tens <= timer_ones == 4'd0 ? timer_tens - 4'd1 : timer_tens;
            if (timer_tens == 4'd0 && timer_ones == 4'd1) state <= SWITCH;
          end
        SWITCH: begin
          player_digit <= player_digit == P1 ? P2 : P1;
          timer_tens <= R_TENS;
          timer_ones <= R_ONES;
          state <= PLAY;
        end
        OVER:
          if (start) begin
            score_p1 <= '0;
            score_p2 <= '0;
            pairs <= '0;
            winner_digit <= WINNER_NONE;
            game_over <= 1'b0;
            player_digit <= P1;
            timer_tens <= R_TENS;
            timer_ones <= R_ONES;
            state <= PLAY;
          end
      endcase
    end
  end
endmodule
